mips32_fetch_queue: RTL and testbench

// - Instruction-fetch front end feeding the ID stage of the MIPS32 pipeline.
// - Generates word-addressed PCs, reads instruction memory over a req/gnt port and buffers {IR, NPC} pairs in a small FIFO.
// - Presents the buffered pairs to decode over a valid/ready handshake.
// - Accepts branch redirects from EX (flush plus new PC) and a halt input from WB.

---
 rtl/mips32_pkg.sv | 53 +++++
 rtl/mips32_fq_fifo.sv | 61 ++++++
 rtl/mips32_fetch_queue.sv | 126 ++++++++++++
 tb/tb_mips32_fetch_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, instruction classes and the
// fetch-queue entry layout.
package mips32_pkg;

    localparam int unsigned IR_W    = 32;
    localparam int unsigned NPC_W   = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ENTRY_W = IR_W + NPC_W;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_AND   = 6'b000010;
    localparam logic [OP_W-1:0] OP_OR    = 6'b000011;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b000100;
    localparam logic [OP_W-1:0] OP_MUL   = 6'b000101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b001000;
    localparam logic [OP_W-1:0] OP_SW    = 6'b001001;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SUBI  = 6'b001011;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_BNEQZ = 6'b001101;
    localparam logic [OP_W-1:0] OP_BEQZ  = 6'b001110;
    localparam logic [OP_W-1:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        TYPE_RR_ALU = 3'd0,
        TYPE_RM_ALU = 3'd1,
        TYPE_LOAD   = 3'd2,
        TYPE_STORE  = 3'd3,
        TYPE_BRANCH = 3'd4,
        TYPE_HALT   = 3'd5
    } instr_type_t;

    typedef struct packed {
        logic [IR_W-1:0]  ir;
        logic [NPC_W-1:0] npc;
    } fetch_entry_t;

    // Instruction class from the opcode field; unknown opcodes decode as HALT.
    function automatic instr_type_t instr_type(input logic [IR_W-1:0] ir);
        logic [OP_W-1:0] op;
        op = ir[IR_W-1 -: OP_W];
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: instr_type = TYPE_RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     instr_type = TYPE_RM_ALU;
            OP_LW:                                         instr_type = TYPE_LOAD;
            OP_SW:                                         instr_type = TYPE_STORE;
            OP_BNEQZ, OP_BEQZ:                             instr_type = TYPE_BRANCH;
            default:                                       instr_type = TYPE_HALT;
        endcase
    endfunction

endpackage

// File: rtl/mips32_fq_fifo.sv
// Synchronous FIFO of fetch entries with flush; DEPTH must be a power of two.
module mips32_fq_fifo
    import mips32_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is accepted only when a pop frees the slot.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch front end: PC, imem req/gnt port and {IR,NPC} queue.
// Define FQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AW       = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic          clk1,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic [31:0]   imem_rdata,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_ir,
    output logic [31:0]   id_npc,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          halt,
    output logic          fq_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [31:0]      pc;
    logic [31:0]      resp_npc;
    logic             pending;
    logic             drop;
    logic             fetch_en;
    logic             grant;
    logic             resp_ok;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // In-flight response reserves a slot so a grant can never overflow the queue.
    always_comb begin
        occupancy        = OCC_W'(count) + OCC_W'(pending);
        imem_req         = fetch_en && !halt && !redirect && !fifo_full
                           && (occupancy < OCC_W'(DEPTH));
        grant            = imem_req && imem_gnt;
        resp_ok          = pending && !drop && !redirect;
        push_entry.ir    = imem_rdata;
        push_entry.npc   = resp_npc;
        imem_addr        = pc[AW-1:0];
        fq_empty         = fifo_empty;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            resp_npc <= '0;
            pending  <= 1'b0;
            drop     <= 1'b0;
            fetch_en <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            pending  <= grant;
            drop     <= redirect;
            if (redirect)   pc <= redirect_pc;
            else if (grant) pc <= pc + 32'd1;
            if (grant)      resp_npc <= pc + 32'd1;
        end
    end

`ifdef FQ_BYPASS_EN
    // Empty queue: the arriving response goes to decode directly, and is only
    // stored if decode does not take it this cycle.
    always_comb begin
        id_valid = 1'b0;
        id_ir    = '0;
        id_npc   = '0;
        push     = resp_ok;
        pop      = 1'b0;
        if (!fifo_empty) begin
            id_valid = 1'b1;
            id_ir    = head.ir;
            id_npc   = head.npc;
            pop      = id_ready;
        end else if (resp_ok) begin
            id_valid = 1'b1;
            id_ir    = imem_rdata;
            id_npc   = resp_npc;
            push     = !id_ready;
        end
    end
`else
    always_comb begin
        id_valid = !fifo_empty;
        id_ir    = '0;
        id_npc   = '0;
        push     = resp_ok;
        pop      = !fifo_empty && id_ready;
        if (!fifo_empty) begin
            id_ir  = head.ir;
            id_npc = head.npc;
        end
    end
`endif

    mips32_fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk1),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Scoreboard bench for mips32_fetch_queue: expected {IR,NPC} queued at each grant,
// compared on each decode handshake.
module tb_mips32_fetch_queue;

    logic        clk1;
    logic        rst_n;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_npc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fq_empty;

    logic [31:0] mem [1024];
    logic [63:0] sb [$];
    logic        gnt_q;
    logic [9:0]  gnt_addr_q;
    logic [9:0]  last_gnt_addr;
    int          n_checks;
    int          n_errors;
    int          n_grants;
    int          n_pops;

    mips32_fetch_queue dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_ir       (id_ir),
        .id_npc      (id_npc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fq_empty    (fq_empty)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_gnt = 1'b0;
        id_ready = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag);
        imem_gnt = 1'b0;
        id_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 50 && !fq_empty; i++) tick();
        check({tag, "_empty"}, fq_empty, 1);
        check({tag, "_sb_left"}, sb.size(), 0);
    endtask

    // Instruction memory: data returned the cycle after each grant.
    always @(posedge clk1) begin
        #1;
        if (gnt_q) imem_rdata = mem[gnt_addr_q];
    end

    // Scoreboard monitor, sampled mid-cycle for the upcoming edge.
    always @(negedge clk1) begin
        logic [63:0] exp;
        gnt_q = 1'b0;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (id_valid && id_ready) begin
                n_pops++;
                if (sb.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    exp = sb.pop_front();
                    check("pop_entry", {id_ir, id_npc}, exp);
                end
            end
            if (redirect) sb.delete();
            if (imem_req && imem_gnt) begin
                gnt_q         = 1'b1;
                gnt_addr_q    = imem_addr;
                last_gnt_addr = imem_addr;
                n_grants++;
                sb.push_back({mem[imem_addr], 32'(imem_addr) + 32'd1});
            end
        end
    end

    initial begin
        #200000;
        check("watchdog", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int g0;
        int p0;
        int vcnt;
        n_checks = 0; n_errors = 0; n_grants = 0; n_pops = 0;
        gnt_q = 1'b0; gnt_addr_q = '0; last_gnt_addr = '0;
        imem_rdata = '0; redirect_pc = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2801000A + 32'(i);

        // Reset state
        rst_n = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
        tick();
        tick();
        check("rst_req", imem_req, 0);
        check("rst_valid", id_valid, 0);
        check("rst_empty", fq_empty, 1);
        check("rst_ir", id_ir, 0);
        check("rst_npc", id_npc, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_req", imem_req, 1);
        check("post_rst_addr", imem_addr, 0);
        check("post_rst_valid", id_valid, 0);

        // Stream: latency then one instruction per cycle
        imem_gnt = 1'b1; id_ready = 1'b1;
        tick();
`ifdef FQ_BYPASS_EN
        check("lat1_valid", id_valid, 1);
        check("lat1_ir", id_ir, 32'h2801000A);
        check("lat1_npc", id_npc, 1);
        tick();
`else
        check("lat1_valid", id_valid, 0);
        tick();
        check("lat2_valid", id_valid, 1);
        check("lat2_ir", id_ir, 32'h2801000A);
        check("lat2_npc", id_npc, 1);
`endif
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (id_valid) vcnt++;
        end
        check("stream_rate", vcnt, 6);
        drain("stream");

        // Backpressure: queue fills, fetch stops, then resumes at address 4
        do_reset();
        id_ready = 1'b0; imem_gnt = 1'b1; g0 = n_grants;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!imem_req) break;
        end
        tick(); tick(); tick();
        check("bp_grants", n_grants - g0, 4);
        check("bp_req_off", imem_req, 0);
        check("bp_addr", imem_addr, 4);
        check("bp_full", fq_empty, 0);
        id_ready = 1'b1;
        for (int i = 0; i < 20 && n_grants <= g0 + 4; i++) tick();
        check("bp_resume_addr", last_gnt_addr, 4);
        drain("bp");

        // Redirect while a response is pending
        imem_gnt = 1'b1; id_ready = 1'b1;
        tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h20;
        #1;
        check("redir_no_req", imem_req, 0);
        @(posedge clk1); #1;
        redirect = 1'b0;
        check("redir_valid_off", id_valid, 0);
        for (int i = 0; i < 10 && !id_valid; i++) tick();
        check("redir_ir", id_ir, 32'h2801002A);
        check("redir_npc", id_npc, 32'h21);
        drain("redir");

        // Halt with two entries queued
        id_ready = 1'b0; imem_gnt = 1'b1; g0 = n_grants;
        tick(); tick();
        halt = 1'b1;
        tick(); tick(); tick();
        check("halt_grants", n_grants - g0, 2);
        check("halt_req", imem_req, 0);
        check("halt_queued", fq_empty, 0);
        p0 = n_pops;
        id_ready = 1'b1;
        for (int i = 0; i < 20 && !fq_empty; i++) tick();
        tick(); tick();
        check("halt_delivered", n_pops - p0, 2);
        check("halt_empty", fq_empty, 1);
        check("halt_req_still", imem_req, 0);
        halt = 1'b0;
        drain("halt");

        // Asynchronous reset between clock edges
        imem_gnt = 1'b1; id_ready = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", id_valid, 0);
        check("ar_empty", fq_empty, 1);
        check("ar_req", imem_req, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_restart_req", imem_req, 1);
        check("ar_restart_addr", imem_addr, 0);
        p0 = n_pops; id_ready = 1'b1;
        for (int i = 0; i < 10 && n_pops == p0; i++) tick();
        check("ar_first_pop", n_pops - p0 > 0, 1);
        drain("ar");

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
